fc_pe_feeder: RTL

//  Sequencer that drives one FC processing element.
//  - Reads the input-activation buffer and the weight buffer, N_INPUTS entries each.
//  - Issues the operand pairs to the PE, spaced so the PE's accumulate loop settles between pairs.
//  - Waits out the PE pipeline, captures the accumulated sum and hands it downstream

---
 rtl/fc_pe_feeder_if.sv | 25 ++
 rtl/fc_pe_feeder.sv | 99 +++++++++
 2 files changed

// File: rtl/fc_pe_feeder_if.sv
// fc_pe_feeder_if: start/busy/result handshake, buffer read port and PE operand bus of the FC PE feeder.
interface fc_pe_feeder_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
);
   logic                    start;
   logic                    busy;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [DATA_WIDTH-1:0]   in_rd_data;
   logic [DATA_WIDTH-1:0]   w_rd_data;
   logic [DATA_WIDTH-1:0]   input_fc;
   logic [DATA_WIDTH-1:0]   iweight_FC;
   logic                    start_FC;
   logic [2*DATA_WIDTH-1:0] output_fc;
   logic [2*DATA_WIDTH-1:0] result_fc;
   logic                    result_valid;
   modport master (
      input  start, in_rd_data, w_rd_data, output_fc,
      output busy, rd_addr, input_fc, iweight_FC, start_FC, result_fc, result_valid
   );
   modport slave (
      output start, in_rd_data, w_rd_data, output_fc,
      input  busy, rd_addr, input_fc, iweight_FC, start_FC, result_fc, result_valid
   );
endinterface

// File: rtl/fc_pe_feeder.sv
// fc_pe_feeder: reads activation/weight buffers, feeds spaced operand pairs to one FC PE, captures its sum.
// Define FC_FEEDER_RELU_EN to clamp negative captured results to zero.
module fc_pe_feeder #(
   parameter int DATA_WIDTH   = 16,
   parameter int N_INPUTS     = 16,
   parameter int ADDR_WIDTH   = 4,
   parameter int STEP_CYCLES  = 4,
   parameter int DRAIN_CYCLES = 6
) (
   input logic            clk,
   input logic            reset,
   fc_pe_feeder_if.master bus
);
   localparam int MAX_CNT = STEP_CYCLES > DRAIN_CYCLES ? STEP_CYCLES : DRAIN_CYCLES;
   localparam int CW = $clog2(MAX_CNT + 1);
   localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_INPUTS - 1);
   if (STEP_CYCLES < 1 || DRAIN_CYCLES < 1 || N_INPUTS < 1 || N_INPUTS > 2**ADDR_WIDTH) begin : g_bad_params
      $error("fc_pe_feeder: illegal STEP_CYCLES/DRAIN_CYCLES/N_INPUTS/ADDR_WIDTH");
   end
   typedef enum logic [1:0] {IDLE, CLEAR, FEED, DRAIN} state_t;
   state_t                  r_state, w_state;
   logic [CW-1:0]           r_cnt, w_cnt;
   logic [ADDR_WIDTH-1:0]   r_idx, w_idx, w_addr, r_rd_addr;
   logic [DATA_WIDTH-1:0]   r_in, r_w;
   logic [2*DATA_WIDTH-1:0] r_result, w_res;
   logic                    w_load, w_cap, r_start_fc, r_busy, r_valid;
   // r_cnt is the step phase in FEED (0 = load cycle) and the drain age in DRAIN
   always_comb begin
      w_state = r_state;
      w_cnt = r_cnt;
      w_idx = r_idx;
      w_load = 1'b0;
      w_cap = 1'b0;
      case (r_state)
         IDLE: begin
            w_state = bus.start ? CLEAR : IDLE;
            w_cnt = '0;
            w_idx = '0;
         end
         CLEAR: w_state = FEED;
         FEED: begin
            w_load = r_cnt == '0;
            w_cnt = r_cnt == STEP_LAST ? '0 : r_cnt + CW'(1);
            w_idx = r_cnt == STEP_LAST && r_idx != LAST_IDX ? r_idx + ADDR_WIDTH'(1) : r_idx;
            if (w_load && r_idx == LAST_IDX) begin
               w_state = DRAIN;
               w_cnt = '0;
            end
         end
         default: begin
            w_cap = r_cnt == DRAIN_LAST;
            w_state = w_cap ? IDLE : DRAIN;
            w_cnt = r_cnt + CW'(1);
         end
      endcase
      // address leads the load by one cycle so buffer data arrives exactly on the load cycle
      w_addr = w_state inside {FEED, DRAIN} ?
               (w_idx == LAST_IDX ? LAST_IDX : w_idx + ADDR_WIDTH'(w_cnt == STEP_LAST)) : '0;
`ifdef FC_FEEDER_RELU_EN
      w_res = bus.output_fc[2*DATA_WIDTH-1] ? '0 : bus.output_fc;
`else
      w_res = bus.output_fc;
`endif
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt <= '0;
         r_idx <= '0;
         r_rd_addr <= '0;
         r_in <= '0;
         r_w <= '0;
         r_start_fc <= 1'b1;
         r_busy <= 1'b0;
         r_valid <= 1'b0;
         r_result <= '0;
      end else begin
         r_state <= w_state;
         r_cnt <= w_cnt;
         r_idx <= w_idx;
         r_rd_addr <= w_addr;
         r_in <= w_load ? bus.in_rd_data : '0;
         r_w <= w_load ? bus.w_rd_data : '0;
         r_start_fc <= w_state inside {IDLE, CLEAR};
         r_busy <= w_state != IDLE;
         r_valid <= w_cap;
         if (w_cap) r_result <= w_res;
      end
   end
   assign bus.busy = r_busy;
   assign bus.rd_addr = r_rd_addr;
   assign bus.input_fc = r_in;
   assign bus.iweight_FC = r_w;
   assign bus.start_FC = r_start_fc;
   assign bus.result_fc = r_result;
   assign bus.result_valid = r_valid;
endmodule
